// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand modular adder: registered 3:2 carry-save levels followed
// by a registered carry-propagate stage, with a valid/ready bubble-collapsing pipeline.
module csa_tree_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_sum,
  output logic [WIDTH-1:0]        out_cs_sum,
  output logic [WIDTH-1:0]        out_cs_carry,
  output logic [TAG_W-1:0]        out_tag
);

  typedef logic [NUM_IN-1:0][WIDTH-1:0] vec_t;

  // Each level turns n operands into n - floor(n/3); count levels until two remain.
  function automatic int level_count(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = c - c / 3;
      l = l + 1;
    end
    return l;
  endfunction

  function automatic int ops_at(input int lvl);
    int c;
    c = NUM_IN;
    for (int j = 0; j < 8; j++) begin
      if (j < lvl) c = c - c / 3;
    end
    return c;
  endfunction

  // Cells pack into the low slots as (sum, shifted carry) pairs; leftovers follow.
  function automatic vec_t csa_level(input vec_t x, input int n);
    vec_t             r;
    int               cells;
    int               idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] mj;
    r     = '0;
    cells = n / 3;
    for (int j = 0; j < NUM_IN / 3; j++) begin
      if (j < cells) begin
        a          = x[3*j];
        b          = x[3*j+1];
        c          = x[3*j+2];
        mj         = (a & b) | (a & c) | (b & c);
        r[2*j]     = a ^ b ^ c;
        r[2*j+1]   = {mj[WIDTH-2:0], 1'b0};
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (k >= cells) ? k - cells : 0;
      if (k >= 3 * cells && k < n) r[idx] = x[k];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cpa_add(input vec_t x);
    return x[0] + x[1];
  endfunction

  localparam int L = level_count(NUM_IN);
  localparam int S = L + 1;

  if (NUM_IN < 3 || NUM_IN > 8) begin : g_bad_num_in
    $fatal(1, "csa_tree_pipe: NUM_IN must lie in 3..8");
  end
  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "csa_tree_pipe: WIDTH must lie in 8..64");
  end

  logic [S-1:0]     v_q;
  logic [S-1:0]     v_d;
  logic [S-1:0]     v_src;
  logic [S-1:0]     adv;
  vec_t             masked;
  vec_t             stage_in [L];
  vec_t             lvl_d    [L];
  vec_t             lvl_q    [L];
  logic [TAG_W-1:0] tag_src  [S];
  logic [TAG_W-1:0] tag_q    [S];
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] cs_sum_q;
  logic [WIDTH-1:0] cs_carry_q;

  // Advance chain runs from the output backwards so a free slot anywhere lets
  // everything upstream of it move.
  always_comb begin
    logic a;
    adv      = '0;
    a        = !v_q[S-1] || out_ready;
    adv[S-1] = a;
    for (int i = S - 2; i >= 0; i--) begin
      a      = !v_q[i] || a;
      adv[i] = a;
    end
  end

  assign in_ready = adv[0];
  assign v_src    = {v_q[S-2:0], in_valid};

  always_comb begin
    for (int i = 0; i < S; i++) begin
      v_d[i] = adv[i] ? v_src[i] : v_q[i];
    end
  end

  always_comb begin
    masked = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_mask[k]) masked[k] = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    stage_in[0] = masked;
    for (int i = 1; i < L; i++) begin
      stage_in[i] = lvl_q[i-1];
    end
    for (int i = 0; i < L; i++) begin
      lvl_d[i] = csa_level(stage_in[i], ops_at(i));
    end
  end

  always_comb begin
    tag_src[0] = in_tag;
    for (int i = 1; i < S; i++) begin
      tag_src[i] = tag_q[i-1];
    end
  end

  assign sum_d = cpa_add(lvl_q[L-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q        <= '0;
      sum_q      <= '0;
      cs_sum_q   <= '0;
      cs_carry_q <= '0;
      for (int i = 0; i < L; i++) lvl_q[i] <= '0;
      for (int i = 0; i < S; i++) tag_q[i] <= '0;
    end else begin
      v_q <= v_d;
      // CSA level boundaries: load only when a valid beat actually moves in
      for (int i = 0; i < L; i++) begin
        if (adv[i] && v_src[i]) lvl_q[i] <= lvl_d[i];
      end
      for (int i = 0; i < S; i++) begin
        if (adv[i] && v_src[i]) tag_q[i] <= tag_src[i];
      end
      // Carry-propagate stage boundary
      if (adv[S-1] && v_src[S-1]) begin
        sum_q      <= sum_d;
        cs_sum_q   <= lvl_q[L-1][0];
        cs_carry_q <= lvl_q[L-1][1];
      end
    end
  end

  assign out_valid    = v_q[S-1];
  assign out_sum      = sum_q;
  assign out_cs_sum   = cs_sum_q;
  assign out_cs_carry = cs_carry_q;
  assign out_tag      = tag_q[S-1];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed and randomized bench for csa_tree_pipe: scoreboard of plain modular sums,
// handshake/stall checks on the default instance and latency/sum sweep on other sizes.
module tb_csa_tree_pipe;
  localparam int W  = 32;
  localparam int N  = 5;
  localparam int TW = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_mask;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [W-1:0]  out_cs_sum;
  logic [W-1:0]  out_cs_carry;
  logic [TW-1:0] out_tag;

  csa_tree_pipe #(.WIDTH(W), .NUM_IN(N), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cs_sum(out_cs_sum), .out_cs_carry(out_cs_carry), .out_tag(out_tag)
  );

  // Sweep instances share one random operand set
  logic        sw_valid;
  logic [63:0] sw_ops [8];
  logic [7:0]  sw_mask;
  logic [3:0]  sw_tag;
  logic [23:0]  d3_data;
  logic [255:0] d4_data;
  logic [191:0] d6_data;
  logic [511:0] d8_data;
  always_comb begin
    for (int k = 0; k < 3; k++) d3_data[k*8 +: 8]   = sw_ops[k][7:0];
    for (int k = 0; k < 4; k++) d4_data[k*64 +: 64] = sw_ops[k];
    for (int k = 0; k < 6; k++) d6_data[k*32 +: 32] = sw_ops[k][31:0];
    for (int k = 0; k < 8; k++) d8_data[k*64 +: 64] = sw_ops[k];
  end

  logic r3_ir, r3_ov, r4_ir, r4_ov, r6_ir, r6_ov, r8_ir, r8_ov;
  logic [7:0]  r3_s, r3_cs, r3_cc;
  logic [63:0] r4_s, r4_cs, r4_cc;
  logic [31:0] r6_s, r6_cs, r6_cc;
  logic [63:0] r8_s, r8_cs, r8_cc;
  logic [3:0]  r3_t, r4_t, r6_t, r8_t;

  csa_tree_pipe #(.WIDTH(8), .NUM_IN(3), .TAG_W(4)) dut3 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r3_ir),
    .in_data(d3_data), .in_mask(sw_mask[2:0]), .in_tag(sw_tag),
    .out_valid(r3_ov), .out_ready(1'b1), .out_sum(r3_s),
    .out_cs_sum(r3_cs), .out_cs_carry(r3_cc), .out_tag(r3_t));
  csa_tree_pipe #(.WIDTH(64), .NUM_IN(4), .TAG_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r4_ir),
    .in_data(d4_data), .in_mask(sw_mask[3:0]), .in_tag(sw_tag),
    .out_valid(r4_ov), .out_ready(1'b1), .out_sum(r4_s),
    .out_cs_sum(r4_cs), .out_cs_carry(r4_cc), .out_tag(r4_t));
  csa_tree_pipe #(.WIDTH(32), .NUM_IN(6), .TAG_W(4)) dut6 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r6_ir),
    .in_data(d6_data), .in_mask(sw_mask[5:0]), .in_tag(sw_tag),
    .out_valid(r6_ov), .out_ready(1'b1), .out_sum(r6_s),
    .out_cs_sum(r6_cs), .out_cs_carry(r6_cc), .out_tag(r6_t));
  csa_tree_pipe #(.WIDTH(64), .NUM_IN(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r8_ir),
    .in_data(d8_data), .in_mask(sw_mask), .in_tag(sw_tag),
    .out_valid(r8_ov), .out_ready(1'b1), .out_sum(r8_s),
    .out_cs_sum(r8_cs), .out_cs_carry(r8_cc), .out_tag(r8_t));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_sum(input int n, input int w,
                                            input logic [63:0] ops [8], input logic [7:0] m);
    logic [63:0] acc;
    acc = 64'd0;
    for (int k = 0; k < n; k++) if (m[k]) acc = acc + ops[k];
    if (w < 64) acc = acc & ((64'd1 << w) - 64'd1);
    return acc;
  endfunction

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  tag;
    int          acc;
  } exp_t;
  exp_t sbq [$];

  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int first_out = -1;
  int last_out = 0;
  bit lat_chk = 1'b1;
  logic [31:0] last_sum;
  logic [3:0]  last_tag;
  logic        prev_stall = 1'b0;
  logic [31:0] held_sum, held_cs, held_cc;
  logic [3:0]  held_tag;

  // One cycle on the default instance: inputs already driven at this negedge.
  task automatic step();
    exp_t e;
    int occ;
    logic [63:0] ops [8];
    logic [31:0] cs_tot;
    #1;
    occ = sbq.size();
    chk("in_ready", in_ready, !(occ == S && !out_ready));
    if (occ == 0) chk("idle_valid", out_valid, 1'b0);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_sum", out_sum, held_sum);
      chk("stall_tag", out_tag, held_tag);
      chk("stall_cs", out_cs_sum, held_cs);
      chk("stall_cc", out_cs_carry, held_cc);
    end
    if (out_valid && out_ready && occ > 0) begin
      e = sbq.pop_front();
      cs_tot = out_cs_sum + out_cs_carry;
      chk("out_sum", out_sum, e.sum);
      chk("out_tag", out_tag, e.tag);
      chk("cs_pair", cs_tot, e.sum);
      if (lat_chk) chk("latency", cyc - e.acc, 4);
      last_sum = out_sum;
      last_tag = out_tag;
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (in_valid && in_ready) begin
      for (int k = 0; k < 8; k++) ops[k] = (k < N) ? {32'd0, in_data[k*W +: W]} : 64'd0;
      e.sum = model_sum(N, W, ops, {3'b000, in_mask}) ;
      e.tag = in_tag;
      e.acc = cyc;
      sbq.push_back(e);
      n_in++;
    end
    prev_stall = out_valid && !out_ready;
    held_sum = out_sum;
    held_tag = out_tag;
    held_cs  = out_cs_sum;
    held_cc  = out_cs_carry;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                      input logic [31:0] o3, input logic [31:0] o4,
                      input logic [N-1:0] m, input logic [TW-1:0] t);
    in_data  = {o4, o3, o2, o1, o0};
    in_mask  = m;
    in_tag   = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sweep_round(input logic [7:0] m);
    logic [63:0] e3, e4, e6, e8;
    for (int k = 0; k < 8; k++) sw_ops[k] = {$urandom, $urandom};
    sw_mask  = m;
    sw_tag   = 4'($urandom);
    sw_valid = 1'b1;
    e3 = model_sum(3, 8, sw_ops, m);
    e4 = model_sum(4, 64, sw_ops, m);
    e6 = model_sum(6, 32, sw_ops, m);
    e8 = model_sum(8, 64, sw_ops, m);
    #1;
    chk("sw_ready", {r3_ir, r4_ir, r6_ir, r8_ir}, 4'hF);
    @(negedge clk);
    sw_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("sw3_valid", r3_ov, c == 2);
      chk("sw4_valid", r4_ov, c == 3);
      chk("sw6_valid", r6_ov, c == 4);
      chk("sw8_valid", r8_ov, c == 5);
      if (c == 2) begin
        chk("sw3_sum", r3_s, e3);
        chk("sw3_tag", r3_t, sw_tag);
        chk("sw3_cs", 8'(r3_cs + r3_cc), e3);
      end
      if (c == 3) chk("sw4_sum", r4_s, e4);
      if (c == 4) begin
        chk("sw6_sum", r6_s, e6);
        chk("sw6_cs", 32'(r6_cs + r6_cc), e6);
      end
      if (c == 5) begin
        chk("sw8_sum", r8_s, e8);
        chk("sw8_tag", r8_t, sw_tag);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_mask = '0; in_tag = '0;
    sw_valid = 1'b0; sw_mask = '0; sw_tag = '0;
    for (int k = 0; k < 8; k++) sw_ops[k] = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_tag", out_tag, 4'd0);
    @(negedge clk);

    send(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 5'b11111, 4'd3);
    idle(5);
    chk("basic_sum", last_sum, 32'd15);
    chk("basic_tag", last_tag, 4'd3);

    send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b11111, 4'd4);
    idle(5);
    chk("wrap_all_ones", last_sum, 32'hFFFFFFFB);
    send(32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0, 5'b11111, 4'd5);
    idle(5);
    chk("wrap_msb", last_sum, 32'd0);

    send(32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 5'b10101, 4'd6);
    idle(5);
    chk("mask_sum", last_sum, 32'd90);
    send(32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 5'b00000, 4'd7);
    idle(5);
    chk("mask_zero", last_sum, 32'd0);
    chk("mask_zero_tag", last_tag, 4'd7);

    first_out = -1;
    n0 = n_out;
    for (int i = 0; i < 16; i++)
      send($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 4'(i));
    idle(6);
    chk("tput_count", n_out - n0, 16);
    chk("tput_span", last_out - first_out, 15);

    lat_chk = 1'b0;
    for (int i = 0; i < 120; i++) begin
      out_ready = ($urandom % 2) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_mask   = 5'($urandom);
      in_tag    = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(8);
    chk("bp_in_vs_out", n_out, n_in);
    chk("bp_drained", sbq.size(), 0);

    lat_chk = 1'b1;
    send(32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 5'b11111, 4'd1);
    send(32'd8, 32'd8, 32'd0, 32'd0, 32'd0, 5'b11111, 4'd2);
    send(32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 5'b11111, 4'd3);
    reset = 1'b1;
    in_valid = 1'b1;
    in_tag = 4'hF;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    prev_stall = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_sum", out_sum, 32'd0);
    chk("mid_rst_cs", {out_cs_sum, out_cs_carry}, 64'd0);
    chk("mid_rst_tag", out_tag, 4'd0);
    @(negedge clk);
    cyc++;
    idle(6);
    send(32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 5'b01111, 4'd9);
    idle(5);
    chk("post_rst_sum", last_sum, 32'd1000);
    chk("post_rst_tag", last_tag, 4'd9);

    sweep_round(8'hFF);
    sweep_round(8'($urandom));
    sweep_round(8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined multi-operand adder for the hash datapaths (e.g. SHA-256 T1 = h + Σ1 + Ch + K + W).
- Reduces NUM_IN operands of WIDTH bits through a tree of registered 3:2 carry-save levels, then a registered carry-propagate adder.
- Result is modulo 2^WIDTH.
- Valid/ready handshake with bubble-collapsing stall logic and a per-beat tag and operand mask.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- NUM_IN, 5, number of operands; legal range 3..8. Other values are a fatal elaboration error.
- TAG_W, 4, width of the sideband tag carried alongside each beat.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  NUM_IN*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- in_mask  in  NUM_IN  operand k contributes only when in_mask[k]=1; otherwise it is replaced by zero.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum of the unmasked operands, mod 2^WIDTH.
- out_cs_sum  out  WIDTH  carry-save sum vector from the final CSA level, as registered.
- out_cs_carry  out  WIDTH  carry vector from the final CSA level, already shifted left by 1 with its MSB dropped.
- out_tag  out  TAG_W  tag of the beat.

Behaviour:
- Primitive: each 3:2 cell computes s = a^b^c and c = maj(a,b,c).
- Carry vectors are shifted left 1 (LSB=0, MSB discarded) before entering the next level, so (s + c_shifted) mod 2^W is invariant at every level.
- Level count L from NUM_IN: 3→1, 4→2, 5→3, 6→3, 7→4, 8→4.
- Each level applies floor(n/3) cells; leftover operands pass through registered.
- The final stage adds the two remaining vectors and registers the result.
- Pipeline has L+1 register stages, each with its own valid bit v[i]; latency from input acceptance to out_valid is L+1 cycles (5 → 4 cycles).
- Stage advance rule: stage i loads when v[i]=0 or stage i+1 is loading or emptying; the last stage empties when out_valid && out_ready.
- in_ready = !v[0] || stage-0-advance. It is combinational from out_ready through the chain; no other combinational input→output path is allowed.
- Full throughput: one beat per cycle while out_ready=1.
- Bubbles collapse: an empty stage loads even when downstream is stalled.
- Stall: while out_valid && !out_ready, all out_* outputs hold stable and no data register changes in any stage whose valid is set and cannot advance.
- Data/tag registers load only on advance. Their reset value is 0 for determinism.
- Mask is applied before level 0; a beat with in_mask = 0 yields out_sum = 0.
- Reset (synchronous, any cycle, including mid-flight): all v[i] clear next edge; in-flight beats are discarded.
  - Outputs after reset: out_valid=0, out_sum/out_cs_*/out_tag=0, in_ready=1 in the first cycle after reset deasserts.
  - Beats presented while reset=1 are not accepted.
- Overflow: carries beyond bit WIDTH-1 are discarded silently; no overflow flag.
- Ordering: results exit strictly in acceptance order; out_tag identifies each beat.

Test Plan:
- Basic, 5 operands, mask=5'b11111, operands 1,2,3,4,5, tag=3 → out_valid exactly 4 cycles after accept, out_sum=15, out_tag=3, (out_cs_sum+out_cs_carry) mod 2^32 = 15.
- Wrap, all operands 0xFFFFFFFF, NUM_IN=5 → out_sum=0xFFFFFFFB; operands 0x80000000 ×2 plus zeros → out_sum=0.
- Mask: operands 10,20,30,40,50 with mask=5'b10101 → out_sum=90; mask=0 → out_sum=0.
- Throughput/backpressure:
  - 16 back-to-back random beats with out_ready=1 → 16 results on consecutive cycles, matching a reference model, in order.
  - Then out_ready toggled pseudo-randomly → no loss or duplication, outputs stable while stalled, in_ready=0 only when all stages are full and stalled.
- Reset mid-flight: accept 3 beats, assert reset for 1 cycle at cycle 2 → no out_valid until a new beat is accepted; that beat's result appears L+1 cycles later and is correct.
- Parameter sweep: NUM_IN=3,4,6,8 and WIDTH=8,64 with random operands → latency equals the table value + 1, and sums match the model mod 2^WIDTH.
